fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 126 ++++++++++++
 tb/tb_fetch_unit.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit -- instruction fetch front end.
//
// Sends sequential fetch requests to instruction memory. Responses come back
// in request order and are buffered in a 2-entry {pc, insn} FIFO for decode.
// A redirect from decode/execute restarts fetch at a word-aligned target. It
// flushes the FIFO and drops any responses still in flight for the old path.
//
// Ports
//   clk, reset_n      clock; asynchronous active-low reset
//   imem_req_o        fetch request valid
//   imem_addr_o       fetch address (held stable while stalled on grant)
//   imem_gnt_i        request accepted this cycle
//   imem_rvalid_i     in-order response valid
//   imem_rdata_i      response instruction word
//   redirect_i        taken branch/jump
//   redirect_pc_i     redirect target (low two bits ignored)
//   insn_valid_o      instruction available to decode
//   insn_ready_i      decode accepts the instruction
//   insn_o, pc_o      FIFO head (zero when empty)
module fetch_unit #(
  parameter int                AWIDTH   = 32,
  parameter int                DWIDTH   = 32,
  parameter logic [AWIDTH-1:0] BASEADDR = 32'h0100_0000
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic              imem_req_o,
  output logic [AWIDTH-1:0] imem_addr_o,
  input  logic              imem_gnt_i,
  input  logic              imem_rvalid_i,
  input  logic [DWIDTH-1:0] imem_rdata_i,
  input  logic              redirect_i,
  input  logic [AWIDTH-1:0] redirect_pc_i,
  output logic              insn_valid_o,
  input  logic              insn_ready_i,
  output logic [DWIDTH-1:0] insn_o,
  output logic [AWIDTH-1:0] pc_o
);

  typedef enum logic {BOOT, RUN} state_t;

  state_t            r_state;
  logic [AWIDTH-1:0] r_fetch_pc;
  logic [AWIDTH-1:0] r_resp_pc;
  logic [1:0]        r_out;       // requests granted, response not yet seen
  logic [1:0]        r_drop;      // in-flight responses belonging to a dead path
  logic [1:0]        r_cnt;       // FIFO occupancy
  logic              r_rd;
  logic              r_wr;
  logic [AWIDTH-1:0] r_fifo_pc   [2];
  logic [DWIDTH-1:0] r_fifo_insn [2];

  logic [2:0]        w_credit;
  logic              w_gnt;
  logic              w_rv;
  logic              w_push;
  logic              w_pop;
  logic [AWIDTH-1:0] w_tgt;
  logic              w_unused;

  // Every outstanding request may land in the FIFO, so reserving a slot per
  // request guarantees a push always finds room.
  assign w_credit   = {1'b0, r_out} + {1'b0, r_cnt};
  assign imem_req_o = (r_state == RUN) && !redirect_i && (w_credit < 3'd2);
  assign w_gnt      = imem_req_o && imem_gnt_i;
  // A response with nothing outstanding is stray and treated as absent.
  assign w_rv       = imem_rvalid_i && (r_out != 2'd0);
  // Responses in the redirect cycle or still owed to an old path are dropped.
  assign w_push     = w_rv && !redirect_i && (r_drop == 2'd0);
  assign w_pop      = insn_valid_o && insn_ready_i;
  assign w_tgt      = {redirect_pc_i[AWIDTH-1:2], 2'b00};
  assign w_unused   = ^redirect_pc_i[1:0];

  assign imem_addr_o  = r_fetch_pc;
  assign insn_valid_o = (r_cnt != 2'd0);
  assign insn_o       = insn_valid_o ? r_fifo_insn[r_rd] : '0;
  assign pc_o         = insn_valid_o ? r_fifo_pc[r_rd]   : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= BOOT;
      r_fetch_pc <= BASEADDR;
      r_resp_pc  <= BASEADDR;
      r_out      <= 2'd0;
      r_drop     <= 2'd0;
      r_cnt      <= 2'd0;
      r_rd       <= 1'b0;
      r_wr       <= 1'b0;
    end else begin
      r_state <= RUN;
      // No grant can coincide with a redirect, so this covers both paths.
      r_out   <= r_out + {1'b0, w_gnt} - {1'b0, w_rv};
      if (redirect_i) begin
        // A handshake this cycle already delivered its word; everything else
        // in the FIFO belongs to the old path.
        r_fetch_pc <= w_tgt;
        r_resp_pc  <= w_tgt;
        r_cnt      <= 2'd0;
        r_rd       <= 1'b0;
        r_wr       <= 1'b0;
        r_drop     <= r_out - {1'b0, w_rv};
      end else begin
        if (w_gnt)
          r_fetch_pc <= r_fetch_pc + AWIDTH'(4);
        if (w_rv && (r_drop != 2'd0))
          r_drop <= r_drop - 2'd1;
        if (w_push) begin
          r_resp_pc <= r_resp_pc + AWIDTH'(4);
          r_wr      <= ~r_wr;
        end
        if (w_pop)
          r_rd <= ~r_rd;
        r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
      end
    end
  end

  // Payload storage needs no reset; occupancy gates every read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_pc[r_wr]   <= r_resp_pc;
      r_fifo_insn[r_wr] <= imem_rdata_i;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit. A memory responder answers each grant one
// cycle later with data derived from the address. A scoreboard of expected
// PCs is loaded whenever the fetch stream (re)starts and popped on each
// decode handshake.
module tb_fetch_unit;
  localparam logic [31:0] BASE = 32'h0100_0000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        insn_valid_o;
  logic        insn_ready_i = 1'b1;
  logic [31:0] insn_o;
  logic [31:0] pc_o;

  int checks = 0;
  int errors = 0;
  int hs_cnt = 0;
  int h0;
  logic [31:0] e;
  logic [31:0] sb[$];
  logic [31:0] pend[$];
  logic rv_en = 1'b1;
  logic stray = 1'b0;

  fetch_unit dut (
    .clk(clk), .reset_n(reset_n),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .insn_valid_o(insn_valid_o), .insn_ready_i(insn_ready_i),
    .insn_o(insn_o), .pc_o(pc_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] fdat(input logic [31:0] a);
    return a ^ 32'hC3A5_0F69;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic sb_load(input logic [31:0] s);
    sb.delete();
    for (int i = 0; i < 64; i++) sb.push_back(s + 32'(4 * i));
  endtask

  // Memory responder: grant seen at the edge, response during the next cycle.
  initial begin : responder
    logic        g;
    logic [31:0] a;
    forever begin
      @(negedge clk);
      g = imem_req_o & imem_gnt_i;
      a = imem_addr_o;
      @(posedge clk);
      #2;
      if (g && reset_n) pend.push_back(a);
      if (!reset_n) pend.delete();
      if (stray) begin
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'hBAD0_BAD0;
      end else if (rv_en && pend.size() != 0) begin
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = fdat(pend.pop_front());
      end else begin
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
      end
    end
  end

  // Decode-side scoreboard check.
  initial begin : monitor
    logic [31:0] x;
    forever begin
      @(negedge clk);
      if (reset_n && insn_valid_o && insn_ready_i) begin
        hs_cnt++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL unexpected_insn: got pc %h want none", pc_o);
        end else begin
          x = sb.pop_front();
          chk("pc_o", pc_o, x);
          chk("insn_o", insn_o, fdat(x));
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    // Reset values
    repeat (3) step();
    smp();
    chk("rst_req", 32'(imem_req_o), 32'd0);
    chk("rst_valid", 32'(insn_valid_o), 32'd0);
    chk("rst_insn", insn_o, 32'd0);
    chk("rst_pc", pc_o, 32'd0);
    chk("rst_addr", imem_addr_o, BASE);

    // BOOT cycle, then a stalled first request with a stray response
    step(); reset_n = 1'b1;
    smp(); chk("boot_req", 32'(imem_req_o), 32'd0);
    step(); stray = 1'b1;
    smp(); chk("run_req", 32'(imem_req_o), 32'd1);
    chk("run_addr", imem_addr_o, BASE);
    step(); stray = 1'b0;
    smp(); chk("stray_valid", 32'(insn_valid_o), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step(); smp();
      chk("stall_req", 32'(imem_req_o), 32'd1);
      chk("stall_addr", imem_addr_o, BASE);
    end

    // Sequential flow
    step(); sb_load(BASE); imem_gnt_i = 1'b1; h0 = hs_cnt;
    repeat (12) step();
    smp(); chk("seq_flow", 32'(hs_cnt - h0 >= 3), 32'd1);

    // Backpressure: FIFO fills to two, fetch stops
    step(); insn_ready_i = 1'b0;
    repeat (9) step();
    smp(); e = sb[0];
    chk("bp_valid", 32'(insn_valid_o), 32'd1);
    chk("bp_req", 32'(imem_req_o), 32'd0);
    chk("bp_head_pc", pc_o, e);
    chk("bp_head_insn", insn_o, fdat(e));
    step(); insn_ready_i = 1'b1; h0 = hs_cnt;
    repeat (6) step();
    smp(); chk("bp_drain", 32'(hs_cnt - h0 >= 2), 32'd1);

    // Redirect with two responses outstanding
    step(); rv_en = 1'b0;
    repeat (6) step();
    smp(); chk("c_req", 32'(imem_req_o), 32'd0);
    chk("c_valid", 32'(insn_valid_o), 32'd0);
    step(); redirect_i = 1'b1; redirect_pc_i = 32'h0100_0103;
    smp(); chk("c_redir_req", 32'(imem_req_o), 32'd0);
    step(); redirect_i = 1'b0; sb_load(32'h0100_0100); rv_en = 1'b1; h0 = hs_cnt;
    smp(); chk("c_addr", imem_addr_o, 32'h0100_0100);
    repeat (10) step();
    smp(); chk("c_flow", 32'(hs_cnt - h0 >= 2), 32'd1);

    // Redirect coinciding with a response and a decode handshake
    step(); insn_ready_i = 1'b0;
    repeat (6) step();
    smp(); chk("d_full", 32'(insn_valid_o), 32'd1);
    chk("d_full_req", 32'(imem_req_o), 32'd0);
    step(); insn_ready_i = 1'b1; rv_en = 1'b0;
    step(); insn_ready_i = 1'b0;
    smp(); chk("d_req", 32'(imem_req_o), 32'd1);
    step(); insn_ready_i = 1'b1; rv_en = 1'b1;
    redirect_i = 1'b1; redirect_pc_i = 32'h0100_0200;
    smp(); chk("d_redir_valid", 32'(insn_valid_o), 32'd1);
    chk("d_redir_req", 32'(imem_req_o), 32'd0);
    step(); redirect_i = 1'b0; sb_load(32'h0100_0200); h0 = hs_cnt;
    smp(); chk("d_empty", 32'(insn_valid_o), 32'd0);
    chk("d_req_next", 32'(imem_req_o), 32'd1);
    chk("d_addr", imem_addr_o, 32'h0100_0200);
    repeat (10) step();
    smp(); chk("d_flow", 32'(hs_cnt - h0 >= 2), 32'd1);

    // Grant stall, with redirects during the stall
    step(); imem_gnt_i = 1'b0;
    repeat (5) step();
    step(); redirect_i = 1'b1; redirect_pc_i = 32'h0100_0300;
    smp(); chk("e_redir_req", 32'(imem_req_o), 32'd0);
    step(); redirect_i = 1'b0; sb_load(32'h0100_0300);
    smp(); chk("e_req", 32'(imem_req_o), 32'd1);
    chk("e_addr", imem_addr_o, 32'h0100_0300);
    for (int i = 0; i < 4; i++) begin
      step(); smp();
      chk("e_stall_req", 32'(imem_req_o), 32'd1);
      chk("e_stall_addr", imem_addr_o, 32'h0100_0300);
    end
    step(); redirect_i = 1'b1; redirect_pc_i = 32'h0100_0400;
    smp(); chk("e_redir2_req", 32'(imem_req_o), 32'd0);
    step(); redirect_i = 1'b0; sb_load(32'h0100_0400);
    smp(); chk("e_req2", 32'(imem_req_o), 32'd1);
    chk("e_addr2", imem_addr_o, 32'h0100_0400);
    step(); imem_gnt_i = 1'b1; h0 = hs_cnt;
    repeat (10) step();
    smp(); chk("e_flow", 32'(hs_cnt - h0 >= 2), 32'd1);

    // Address wrap at the top of the space
    step(); redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFF8;
    step(); redirect_i = 1'b0; sb_load(32'hFFFF_FFF8); h0 = hs_cnt;
    repeat (20) step();
    smp(); chk("wrap_flow", 32'(hs_cnt - h0 >= 4), 32'd1);

    // Reset mid-burst: outputs return to reset values at once
    step(); reset_n = 1'b0;
    #1;
    chk("mrst_req", 32'(imem_req_o), 32'd0);
    chk("mrst_valid", 32'(insn_valid_o), 32'd0);
    chk("mrst_insn", insn_o, 32'd0);
    chk("mrst_pc", pc_o, 32'd0);
    chk("mrst_addr", imem_addr_o, BASE);
    repeat (2) step();
    reset_n = 1'b1;
    smp(); chk("mrst_boot_req", 32'(imem_req_o), 32'd0);
    step(); sb_load(BASE); h0 = hs_cnt;
    smp(); chk("mrst_req2", 32'(imem_req_o), 32'd1);
    chk("mrst_addr2", imem_addr_o, BASE);
    repeat (12) step();
    smp(); chk("mrst_flow", 32'(hs_cnt - h0 >= 3), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
